fetch_pc_stage: RTL and testbench

//  Instruction-fetch stage, directly upstream of the RVC-aware read-only I-cache.
//  - Owns the PC and drives the cache with a halfword address.
//  - Advances the PC by 2 or 4 using the cache's 32/16-bit indication.
//  - Absorbs cache stalls, decode hazards and EX branch redirects.
//  - Loads the IF/ID pipeline register consumed by decode.

---
 rtl/rv_pkg.sv | 34 +++
 rtl/fetch_pc_gen.sv | 23 ++
 rtl/fetch_pc_stage.sv | 120 ++++++++++++
 tb/tb_fetch_pc_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared fetch-side definitions: reset PC default, little-endian NOP, FSM states,
// next-PC select codes and the IF/ID register layout.
package rv_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_LE       = 32'h1300_0000;

    typedef enum logic {
        S_RUN        = 1'b0,
        S_REDIR_PEND = 1'b1
    } fetch_state_e;

    typedef enum logic [2:0] {
        PC_HOLD  = 3'd0,
        PC_INC2  = 3'd1,
        PC_INC4  = 3'd2,
        PC_REDIR = 3'd3,
        PC_PEND  = 3'd4
    } pc_sel_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] instr;
        logic        is_rvc;
    } ifid_t;

    // Instruction addresses are halfword aligned; bit0 of any target is dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Combinational next-PC select: sequential +2/+4, live redirect, pending redirect or hold.
module fetch_pc_gen
    import rv_pkg::*;
(
    input  logic [31:0] pc_r,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] redir_pend,
    input  pc_sel_e     sel,
    output logic [31:0] pc_nxt
);

    always_comb begin
        pc_nxt = pc_r;
        case (sel)
            PC_INC2:  pc_nxt = pc_r + 32'd2;
            PC_INC4:  pc_nxt = pc_r + 32'd4;
            PC_REDIR: pc_nxt = align_pc(redirect_pc);
            PC_PEND:  pc_nxt = redir_pend;
            default:  pc_nxt = pc_r;
        endcase
    end

endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: owns the PC, drives the I-cache halfword address,
// handles cache stalls, decode hazards and EX redirects, and loads IF/ID.
module fetch_pc_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             icache_stall,
    input  logic             icache_pcadd,
    input  logic [31:0]      icache_rdata,
    output logic             icache_read,
    output logic [30:0]      icache_addr,
    input  logic             hazard_stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             ifid_valid,
    output logic [31:0]      ifid_pc,
    output logic [31:0]      ifid_pc_next,
    output logic [31:0]      ifid_instr,
    output logic             ifid_is_rvc,
    output logic [CNT_W-1:0] perf_fetch_cnt,
    output logic [CNT_W-1:0] perf_rvc_cnt
);

    fetch_state_e     state_r, state_nxt;
    logic [31:0]      pc_r, pc_nxt;
    logic [31:0]      redir_pend_r, redir_pend_nxt;
    ifid_t            ifid_r, ifid_nxt;
    pc_sel_e          pc_sel;
    logic             accept;
    logic [CNT_W-1:0] fetch_cnt_r, rvc_cnt_r;

    fetch_pc_gen u_pc_gen (
        .pc_r        (pc_r),
        .redirect_pc (redirect_pc),
        .redir_pend  (redir_pend_r),
        .sel         (pc_sel),
        .pc_nxt      (pc_nxt)
    );

    always_comb begin
        state_nxt      = state_r;
        redir_pend_nxt = redir_pend_r;
        ifid_nxt       = ifid_r;
        pc_sel         = PC_HOLD;
        accept         = 1'b0;
        case (state_r)
            S_RUN: begin
                if (redirect_valid) begin
                    // Redirect beats hazard_stall: EX squashes whatever sits in ID.
                    ifid_nxt.valid = 1'b0;
                    if (icache_stall) begin
                        redir_pend_nxt = align_pc(redirect_pc);
                        state_nxt      = S_REDIR_PEND;
                    end else begin
                        pc_sel         = PC_REDIR;
                        ifid_nxt.instr = NOP_LE;
                    end
                end else if (hazard_stall) begin
                    pc_sel = PC_HOLD;
                end else if (icache_stall) begin
                    ifid_nxt.valid = 1'b0;
                end else begin
                    accept   = 1'b1;
                    pc_sel   = icache_pcadd ? PC_INC4 : PC_INC2;
                    ifid_nxt = '{valid: 1'b1, pc: pc_r, pc_next: pc_nxt,
                                 instr: icache_rdata, is_rvc: ~icache_pcadd};
                end
            end
            S_REDIR_PEND: begin
                // pc_r stays put so the cache sees a stable address until the miss retires.
                if (icache_stall) begin
                    if (redirect_valid)
                        redir_pend_nxt = align_pc(redirect_pc);
                end else begin
                    pc_sel         = redirect_valid ? PC_REDIR : PC_PEND;
                    ifid_nxt.valid = 1'b0;
                    state_nxt      = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_RUN;
            pc_r         <= RESET_PC;
            redir_pend_r <= '0;
            ifid_r       <= '{valid: 1'b0, pc: RESET_PC, pc_next: RESET_PC,
                              instr: NOP_LE, is_rvc: 1'b0};
            fetch_cnt_r  <= '0;
            rvc_cnt_r    <= '0;
        end else begin
            state_r      <= state_nxt;
            pc_r         <= pc_nxt;
            redir_pend_r <= redir_pend_nxt;
            ifid_r       <= ifid_nxt;
            if (accept) begin
                fetch_cnt_r <= fetch_cnt_r + CNT_W'(1);
                if (!icache_pcadd)
                    rvc_cnt_r <= rvc_cnt_r + CNT_W'(1);
            end
        end
    end

    assign icache_read    = rst_n;
    assign icache_addr    = pc_r[31:1];
    assign ifid_valid     = ifid_r.valid;
    assign ifid_pc        = ifid_r.pc;
    assign ifid_pc_next   = ifid_r.pc_next;
    assign ifid_instr     = ifid_r.instr;
    assign ifid_is_rvc    = ifid_r.is_rvc;
    assign perf_fetch_cnt = fetch_cnt_r;
    assign perf_rvc_cnt   = rvc_cnt_r;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Scoreboard bench for fetch_pc_stage: a reference model pushes expected IF/ID
// contents when a fetch is driven; they are popped and compared after the edge.
module tb_fetch_pc_stage;

    localparam logic [31:0] NOP = 32'h1300_0000;

    logic        clk, rst_n;
    logic        icache_stall, icache_pcadd, hazard_stall, redirect_valid;
    logic [31:0] icache_rdata, redirect_pc;
    logic        icache_read;
    logic [30:0] icache_addr;
    logic        ifid_valid, ifid_is_rvc;
    logic [31:0] ifid_pc, ifid_pc_next, ifid_instr;
    logic [31:0] perf_fetch_cnt, perf_rvc_cnt;

    fetch_pc_stage #(.RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_stall   (icache_stall),
        .icache_pcadd   (icache_pcadd),
        .icache_rdata   (icache_rdata),
        .icache_read    (icache_read),
        .icache_addr    (icache_addr),
        .hazard_stall   (hazard_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_pc_next   (ifid_pc_next),
        .ifid_instr     (ifid_instr),
        .ifid_is_rvc    (ifid_is_rvc),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_rvc_cnt   (perf_rvc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] instr;
        logic        rvc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Reference model state
    logic [31:0] m_pc, m_pend_pc, m_fetch, m_rvc;
    logic        m_pend, m_v;
    exp_t        m_last;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_pend_pc = 32'h0; m_pend = 1'b0; m_v = 1'b0;
        m_fetch = 0; m_rvc = 0;
        m_last = '{pc: 32'h0, pc_next: 32'h0, instr: NOP, rvc: 1'b0};
        sb.delete();
    endtask

    task automatic chk_reset_vals();
        chk("rst_valid",   {31'h0, ifid_valid}, 32'h0);
        chk("rst_pc",      ifid_pc, 32'h0);
        chk("rst_pc_next", ifid_pc_next, 32'h0);
        chk("rst_instr",   ifid_instr, NOP);
        chk("rst_rvc",     {31'h0, ifid_is_rvc}, 32'h0);
        chk("rst_addr",    {1'b0, icache_addr}, 32'h0);
        chk("rst_fcnt",    perf_fetch_cnt, 32'h0);
        chk("rst_rcnt",    perf_rvc_cnt, 32'h0);
    endtask

    // One clock of stimulus; model evaluates the same cycle and checks after the edge.
    task automatic step(input logic st, input logic pa, input logic hz, input logic rv,
                        input logic [31:0] rpc, input logic [31:0] ins);
        exp_t e;
        logic acc, nop;
        logic [31:0] tgt;
        acc = 1'b0; nop = 1'b0;
        tgt = rpc & 32'hFFFF_FFFE;
        icache_stall = st; icache_pcadd = pa; hazard_stall = hz;
        redirect_valid = rv; redirect_pc = rpc; icache_rdata = ins;
        if (m_pend) begin
            if (st) begin
                if (rv) m_pend_pc = tgt;
            end else begin
                m_pc = rv ? tgt : m_pend_pc;
                m_pend = 1'b0; m_v = 1'b0;
            end
        end else if (rv) begin
            m_v = 1'b0;
            if (st) begin m_pend_pc = tgt; m_pend = 1'b1; end
            else begin m_pc = tgt; nop = 1'b1; end
        end else if (!hz) begin
            if (st) m_v = 1'b0;
            else begin
                acc = 1'b1;
                e.pc = m_pc; e.pc_next = m_pc + (pa ? 32'd4 : 32'd2);
                e.instr = ins; e.rvc = ~pa;
                sb.push_back(e);
                m_pc = e.pc_next; m_v = 1'b1;
                m_fetch++; if (!pa) m_rvc++;
            end
        end
        @(posedge clk); #1;
        chk("addr",  {1'b0, icache_addr}, {1'b0, m_pc[31:1]});
        chk("valid", {31'h0, ifid_valid}, {31'h0, m_v});
        if (acc) begin
            if (sb.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL sb_empty: got none expected entry");
            end else begin
                e = sb.pop_front();
                chk("ifid_pc",      ifid_pc, e.pc);
                chk("ifid_pc_next", ifid_pc_next, e.pc_next);
                chk("ifid_instr",   ifid_instr, e.instr);
                chk("ifid_rvc",     {31'h0, ifid_is_rvc}, {31'h0, e.rvc});
                m_last = e;
            end
        end else if (m_v) begin
            chk("hold_pc",    ifid_pc, m_last.pc);
            chk("hold_instr", ifid_instr, m_last.instr);
        end
        if (nop) chk("squash_nop", ifid_instr, NOP);
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_fcnt"}, perf_fetch_cnt, m_fetch);
        chk({tag, "_rcnt"}, perf_rvc_cnt, m_rvc);
    endtask

    initial begin
        rst_n = 1'b0;
        icache_stall = 1'b1; icache_pcadd = 1'b1; hazard_stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; icache_rdata = 32'h0;
        model_reset();
        #12;
        chk_reset_vals();
        @(negedge clk); rst_n = 1'b1;
        #1 chk("read_hi", {31'h0, icache_read}, 32'h1);

        // T1: three 32-bit instructions back to back
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 32'hA000_0000 + i);
        chk_cnts("t1");

        // T2: redirect (bit0 set, ignored) to 0x100 then 32/16/16/32
        step(0, 1, 0, 1, 32'h0000_0101, 32'hDEAD_BEEF);
        step(0, 1, 0, 0, 0, 32'hB000_0001);
        step(0, 0, 0, 0, 0, 32'hB000_0002);
        step(0, 0, 0, 0, 0, 32'hB000_0003);
        step(0, 1, 0, 0, 0, 32'hB000_0004);
        chk_cnts("t2");

        // T3: five stall cycles at 0x40
        step(0, 1, 0, 1, 32'h40, 32'h0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 32'hFFFF_FFFF);
        step(0, 1, 0, 0, 0, 32'hC000_0040);

        // T4: redirect to 0x200 in 3rd stall cycle; stall-end instr discarded
        step(1, 1, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 0, 32'h0);
        step(1, 1, 0, 1, 32'h200, 32'h0);
        step(1, 1, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 0, 32'hBAD0_BAD0);
        step(0, 1, 0, 0, 0, 32'hD000_0200);
        chk_cnts("t4");

        // T4b: newest of two pending redirects wins, even one arriving at stall end
        step(1, 1, 0, 1, 32'h600, 32'h0);
        step(1, 1, 0, 1, 32'h700, 32'h0);
        step(0, 1, 0, 1, 32'h800, 32'h0);
        step(0, 0, 0, 0, 0, 32'hD000_0800);

        // T5: hazard holds with ifid_pc=0x80, then redirect overrides hazard
        step(0, 1, 0, 1, 32'h80, 32'h0);
        step(0, 1, 0, 0, 0, 32'hE000_0080);
        step(0, 1, 1, 0, 0, 32'h1111_1111);
        step(1, 1, 1, 0, 0, 32'h2222_2222);
        step(0, 1, 1, 1, 32'h300, 32'h3333_3333);
        step(0, 1, 0, 0, 0, 32'hE000_0300);
        chk_cnts("t5");

        // T6: wrap at top of address space, then reset mid-miss
        step(0, 1, 0, 1, 32'hFFFF_FFFE, 32'h0);
        step(0, 0, 0, 0, 0, 32'hF000_0001);
        step(1, 1, 0, 0, 0, 32'h0);
        chk_cnts("t6");
        #3 rst_n = 1'b0;
        #1 chk_reset_vals();
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 32'h0000_4501);
        chk_cnts("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
